pipe_adder: RTL
===============

Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the CPU's combinational adders (general a+b and the PC+4 incrementer).
- Splits a WIDTH-bit add/sub/increment into STAGES registered carry-ripple slices. Each cycle it accepts one operation and returns flags.
- Uses a valid/ready handshake with full back-pressure.
- Used by the multi-cycle datapath where a single-cycle 32-bit add limits fmax.

Parameters:
- WIDTH, 32: operand/result width; must be divisible by STAGES.
- STAGES, 4: pipeline depth and number of slices; slice width SW = WIDTH/STAGES. Legal values 1..WIDTH.
- INC_STEP, 4: constant added in OP_INC mode; must fit in WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation present on a/b/op/cin
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored in OP_INC)
- op  in  2  00 OP_ADD, 01 OP_SUB, 10 OP_INC, 11 reserved (executes as OP_ADD)
- cin  in  1  carry-in, used by OP_ADD only
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- r  out  WIDTH  result
- cout  out  1  carry-out of MSB (for OP_SUB, 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  r == 0

Behaviour:
- Reset: asynchronous on rst_n low.
  - All stage valid bits clear.
  - out_valid=0; r=0; cout=0; ovf=0; zero=0.
  - in_ready=1 once rst_n high.
  - Reset mid-operation discards all in-flight operations; no partial result is emitted.
- Effective operands, formed at the input:
  - OP_ADD: B'=b, c0=cin.
  - OP_SUB: B'=~b, c0=1.
  - OP_INC: B'=INC_STEP zero-extended, c0=0.
  - Reserved op: identical to OP_ADD.
- Pipeline:
  - Stage k (k=0..STAGES-1) adds slice k of A and B' with the carry registered by stage k-1 (c0 for k=0).
  - Stage k registers its SW-bit sum slice and carry-out.
  - Unprocessed upper slices of A and B' travel with the operation (operand skew registers).
  - Completed lower sum slices travel with it too (deskew).
- Flags, formed in the last stage:
  - cout = final carry.
  - ovf = (A[MSB]==B'[MSB]) && (r[MSB]!=A[MSB]).
  - zero = ~|r.
- Latency: an operation accepted in cycle t appears with out_valid=1 in cycle t+STAGES when no stall occurs.
- Throughput: 1 operation/cycle.
- Handshake:
  - Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
  - stall = out_valid && !out_ready. Pipeline enable en = !stall; in_ready = en (combinational from out_ready).
  - When en=0 every stage register, including r/flags/out_valid, holds.
  - While out_valid=1 && out_ready=0, the outputs r/cout/ovf/zero are stable.
  - Bubbles (invalid stages) advance when en=1 and never create out_valid.
  - in_valid with in_ready=0 is ignored; the source holds the operation.
- Boundaries:
  - Wrap-around: results are modulo 2^WIDTH, with carry reported on cout.
  - Full pipeline plus stall: no data loss; the operation presented in the same cycle is not accepted.
  - Simultaneous accept and output transfer in one cycle is legal and keeps 1/cycle.
  - STAGES=1: single registered adder, latency 1.
- Internal datapath registers other than valids need no reset.

Decomposition:
- Package pipe_adder_pkg: op encodings OP_ADD/OP_SUB/OP_INC/OP_RSV as 2-bit localparams.
- Sub-module adder_slice (SW-bit combinational a+b+c -> sum, cout), instantiated STAGES times via generate.
- Stage registers and skew/deskew logic stay in pipe_adder.

Test Plan (WIDTH=32, STAGES=4, INC_STEP=4):
- OP_ADD a=0x0000_FFFF, b=0x0000_0001, cin=0, out_ready=1 -> 4 cycles later r=0x0001_0000, cout=0, ovf=0, zero=0. This checks inter-slice carry.
- OP_ADD a=0x7FFF_FFFF, b=1 -> r=0x8000_0000, ovf=1, cout=0. OP_ADD a=0xFFFF_FFFF, b=1 -> r=0, cout=1, zero=1, ovf=0.
- OP_SUB a=5, b=7 -> r=0xFFFF_FFFE, cout=0. OP_SUB a=0x8000_0000, b=1 -> r=0x7FFF_FFFF, ovf=1. OP_INC a=0x0040_0000 -> r=0x0040_0004.
- Back-to-back stream of 8 adds (a=i, b=10·i), with out_ready low for cycles 6–8 -> in_ready low those cycles, outputs held stable. All 8 results (11·i) arrive in order with none lost or duplicated.
- Reset asserted with 3 operations in flight -> out_valid=0 immediately. After release, no stale result appears; the next add 2+3 yields r=5 after 4 cycles.
- Random sweep of 10k operations including reserved op=11 and random out_ready -> every result matches the reference model; reserved op behaves as OP_ADD.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared operation encodings for the pipelined adder.
package pipe_adder_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

endpackage

// File: rtl/adder_slice.sv
// One SW-bit combinational ripple slice: {cout, sum} = a + b + cin.
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/sub/increment: STAGES registered carry-ripple slices with
// operand skew, result deskew and a valid/ready handshake with back-pressure.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 4,
  parameter int INC_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // x_in[k] holds completed sum slices below slice k and raw A above it.
  logic [STAGES-1:0][WIDTH-1:0] x_in;
  logic [STAGES-1:0]            c_in;
  logic [STAGES-1:0]            v_in;

  // The whole pipeline freezes only while a finished result is refused.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    b_eff = b;
    c0    = cin;
    case (op)
      OP_SUB: begin
        b_eff = ~b;
        c0    = 1'b1;
      end
      OP_INC: begin
        b_eff = WIDTH'(INC_STEP);
        c0    = 1'b0;
      end
      OP_ADD, OP_RSV: begin
        b_eff = b;
        c0    = cin;
      end
    endcase
  end

  assign x_in[0] = a;
  assign c_in[0] = c0;
  assign v_in[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;
    localparam int RW = WIDTH - LO;

    logic [RW-1:0]    y_cur;
    logic [SW-1:0]    s_slice;
    logic             c_slice;
    logic [WIDTH-1:0] x_nxt;

    // Only the not-yet-added upper part of B' travels down the pipe.
    if (k == 0) begin : g_first
      assign y_cur = b_eff;
    end else begin : g_chain
      assign y_cur = g_stage[k-1].g_mid.y_r;
    end

    adder_slice #(.SW(SW)) u_slice (
      .a    (x_in[k][LO +: SW]),
      .b    (y_cur[SW-1:0]),
      .cin  (c_in[k]),
      .sum  (s_slice),
      .cout (c_slice)
    );

    always_comb begin
      x_nxt            = x_in[k];
      x_nxt[LO +: SW]  = s_slice;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [RW-SW-1:0] y_r;
      logic [WIDTH-1:0] x_r;
      logic             c_r;
      logic             v_r;

      // NOTE: datapath registers carry no reset; only valid bits decide what is live.
      always_ff @(posedge clk) begin
        if (en) begin
          x_r <= x_nxt;
          y_r <= y_cur[RW-1:SW];
          c_r <= c_slice;
        end
      end

      // NOTE: sequential state uses non-blocking assignment only.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_r <= 1'b0;
        end else if (en) begin
          v_r <= v_in[k];
        end
      end

      assign x_in[k+1] = x_r;
      assign c_in[k+1] = c_r;
      assign v_in[k+1] = v_r;
    end else begin : g_last
      // Result registers load only on a real operation so r keeps the last answer.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          r         <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (en) begin
          out_valid <= v_in[k];
          if (v_in[k]) begin
            r    <= x_nxt;
            cout <= c_slice;
            ovf  <= (x_in[k][WIDTH-1] == y_cur[RW-1]) &&
                    (x_nxt[WIDTH-1] != x_in[k][WIDTH-1]);
            zero <= ~|x_nxt;
          end
        end
      end
    end
  end

endmodule
